// File: rtl/bcdbin_arbiter.sv
// bcdbin_arbiter: round-robin sharing of one bcd2bin converter between NREQ
// requesters. One conversion in flight at a time; every output is registered.
// Optional build macro BCDBIN_ARB_DIGIT_CHECK_EN: rejects winners carrying a
// digit above 9 without launching the converter (err=1, bin_out=7'h7F).
module bcdbin_arbiter #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [4*NREQ-1:0]    dig1_in,
    input  logic [4*NREQ-1:0]    dig0_in,
    output logic [NREQ-1:0]      ack,
    output logic [6:0]           bin_out,
    output logic                 err,
    output logic                 busy,
    output logic                 conv_start,
    output logic [3:0]           conv_dig1,
    output logic [3:0]           conv_dig0,
    input  logic [6:0]           conv_bin,
    input  logic                 conv_ready,
    input  logic                 conv_done_tick
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    state_t            state_next;
    logic [IDXW-1:0]   last;
    logic [IDXW-1:0]   idx;
    logic [IDXW-1:0]   win;
    logic [IDXW-1:0]   cand_idx;
    int                cand;
    logic              found;
    logic              grant;
    logic              digit_bad;
    logic [3:0]        win_dig1;
    logic [3:0]        win_dig0;
    logic [NREQ-1:0]   one;

    assign one = {{(NREQ-1){1'b0}}, 1'b1};

    // Round-robin search starting just after the last served requester
    always_comb begin
        found    = 1'b0;
        win      = last;
        cand     = 0;
        cand_idx = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand     = (int'(last) + off) % NREQ;
            cand_idx = cand[IDXW-1:0];
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                win   = cand_idx;
            end
        end
    end

    assign win_dig1 = dig1_in[{win, 2'b00} +: 4];
    assign win_dig0 = dig0_in[{win, 2'b00} +: 4];
    assign grant    = (state == IDLE) && found && conv_ready;

`ifdef BCDBIN_ARB_DIGIT_CHECK_EN
    assign digit_bad = (win_dig1 > 4'd9) || (win_dig0 > 4'd9);
`else
    assign digit_bad = 1'b0;
`endif

    // Next-state selection
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = digit_bad ? RESP : ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (conv_done_tick) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Registered outputs, grant bookkeeping and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last       <= IDXW'(NREQ - 1);
            idx        <= '0;
            ack        <= '0;
            bin_out    <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            conv_start <= 1'b0;
            conv_dig1  <= '0;
            conv_dig0  <= '0;
        end else begin
            busy       <= (state_next != IDLE);
            conv_start <= (state_next == ISSUE);
            ack        <= '0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        idx       <= win;
                        conv_dig1 <= win_dig1;
                        conv_dig0 <= win_dig0;
                        if (digit_bad) begin
                            bin_out <= 7'h7F;
                            err     <= 1'b1;
                            ack     <= one << win;
                        end
                    end
                end
                WAIT: begin
                    if (conv_done_tick) begin
                        bin_out <= conv_bin;
                        err     <= 1'b0;
                        ack     <= one << idx;
                    end
                end
                RESP:    last <= idx;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcdbin_arbiter.sv
// Directed bench for bcdbin_arbiter with a behavioural bcd2bin stand-in.
module tb_bcdbin_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] dig1_in;
    logic [15:0] dig0_in;
    logic [3:0]  ack;
    logic [6:0]  bin_out;
    logic        err;
    logic        busy;
    logic        conv_start;
    logic [3:0]  conv_dig1;
    logic [3:0]  conv_dig0;
    logic [6:0]  conv_bin;
    logic        conv_ready;
    logic        conv_done_tick;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;
    int lat = 2;
    int cnt;
    int n;
    int s0;

    bcdbin_arbiter #(.NREQ(4), .IDXW(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .dig1_in(dig1_in), .dig0_in(dig0_in),
        .ack(ack), .bin_out(bin_out), .err(err), .busy(busy), .conv_start(conv_start),
        .conv_dig1(conv_dig1), .conv_dig0(conv_dig0), .conv_bin(conv_bin),
        .conv_ready(conv_ready), .conv_done_tick(conv_done_tick)
    );

    always #5 clk = ~clk;

    // Converter stand-in: done_tick 'lat' cycles after the start pulse
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= 0;
            conv_done_tick <= 1'b0;
            conv_bin       <= '0;
        end else if (conv_start) begin
            cnt            <= lat - 1;
            conv_done_tick <= (lat == 1);
            conv_bin       <= 7'(int'(conv_dig1) * 10 + int'(conv_dig0));
        end else if (cnt > 0) begin
            cnt            <= cnt - 1;
            conv_done_tick <= (cnt == 1);
            conv_bin       <= 7'(int'(conv_dig1) * 10 + int'(conv_dig0));
        end else begin
            conv_done_tick <= 1'b0;
        end
    end

    always @(posedge clk) if (conv_start === 1'b1) start_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic wait_ack(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (ack == '0 && cycles < 40);
        if (ack == '0) begin
            total++;
            bad++;
            $error("FAIL ack_timeout observed=none expected=ack within 40 cycles");
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; dig1_in = '0; dig0_in = '0; conv_ready = 1'b1;
        tick();
        tick();
        // Reset state
        chk("rst_ack", ack, 0);
        chk("rst_bin", bin_out, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", conv_start, 0);
        chk("rst_dig1", conv_dig1, 0);
        chk("rst_dig0", conv_dig0, 0);
        rst_n = 1'b1;
        tick();

        // Single conversion 42 on requester 0, L=2
        dig1_in[3:0] = 4'd4; dig0_in[3:0] = 4'd2; req = 4'b0001;
        s0 = start_cnt;
        tick();
        chk("single_start", conv_start, 1);
        chk("single_busy", busy, 1);
        chk("single_dig1", conv_dig1, 4);
        chk("single_dig0", conv_dig0, 2);
        wait_ack(n);
        chk("single_latency", n + 1, 4);
        chk("single_ack", ack, 4'b0001);
        chk("single_bin", bin_out, 42);
        chk("single_err", err, 0);
        req = '0;
        tick();
        chk("single_ack_drop", ack, 0);
        chk("single_idle_busy", busy, 0);
        chk("single_bin_hold", bin_out, 42);
        chk("single_nstart", start_cnt - s0, 1);

        // All four requesting at once, fresh reset so requester 0 leads
        do_reset();
        dig1_in = {4'd7, 4'd1, 4'd0, 4'd9};
        dig0_in = {4'd3, 4'd5, 4'd0, 4'd9};
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_ack(n);
            chk("all_ack", ack, 32'(4'b0001 << i));
            case (i)
                0: chk("all_bin0", bin_out, 99);
                1: chk("all_bin1", bin_out, 0);
                2: chk("all_bin2", bin_out, 15);
                default: chk("all_bin3", bin_out, 73);
            endcase
            req[i] = 1'b0;
            tick();
            chk("all_idle_busy", busy, 0);
            if (i < 3) begin
                tick();
                chk("all_busy_again", busy, 1);
                chk("all_start_again", conv_start, 1);
            end
        end

        // Fairness between requesters 1 and 3 held continuously
        dig1_in = {4'd6, 4'd0, 4'd2, 4'd0};
        dig0_in = {4'd0, 4'd0, 4'd5, 4'd0};
        req = 4'b1010;
        for (int t = 0; t < 8; t++) begin
            wait_ack(n);
            if (t % 2 == 0) begin
                chk("fair_ack1", ack, 4'b0010);
                chk("fair_bin1", bin_out, 25);
            end else begin
                chk("fair_ack3", ack, 4'b1000);
                chk("fair_bin3", bin_out, 60);
            end
        end
        req = '0;
        tick();

        // Converter not ready holds the grant back
        conv_ready = 1'b0;
        dig1_in[11:8] = 4'd3; dig0_in[11:8] = 4'd1; req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nrdy_start", conv_start, 0);
            chk("nrdy_busy", busy, 0);
        end
        conv_ready = 1'b1;
        tick();
        chk("rdy_busy", busy, 1);
        chk("rdy_start", conv_start, 1);
        wait_ack(n);
        chk("rdy_ack", ack, 4'b0100);
        chk("rdy_bin", bin_out, 31);
        req = '0;
        tick();

        // Reset while in WAIT abandons the transaction
        dig1_in[11:8] = 4'd8; dig0_in[11:8] = 4'd6; req = 4'b0100;
        tick();
        chk("rw_issue", conv_start, 1);
        tick();
        chk("rw_wait_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rw_ack", ack, 0);
        chk("rw_busy", busy, 0);
        chk("rw_start", conv_start, 0);
        chk("rw_bin", bin_out, 0);
        chk("rw_dig1", conv_dig1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rw_noack", ack, 0);
        end
        rst_n = 1'b1;
        wait_ack(n);
        chk("rw_regrant_ack", ack, 4'b0100);
        chk("rw_regrant_bin", bin_out, 86);
        req = '0;
        tick();

        // Invalid units digit on requester 1
        dig1_in[7:4] = 4'd1; dig0_in[7:4] = 4'hA; req = 4'b0010;
        s0 = start_cnt;
        wait_ack(n);
        chk("inv_ack", ack, 4'b0010);
`ifdef BCDBIN_ARB_DIGIT_CHECK_EN
        chk("inv_latency", n, 1);
        chk("inv_err", err, 1);
        chk("inv_bin", bin_out, 127);
        chk("inv_nstart", start_cnt - s0, 0);
`else
        chk("inv_latency", n, 4);
        chk("inv_err", err, 0);
        chk("inv_nstart", start_cnt - s0, 1);
`endif
        req = '0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcdbin_arbiter.md
# bcdbin_arbiter

Round-robin arbiter and sequencer that shares one `bcd2bin` converter between `NREQ` independent requesters. Each requester presents a two-digit BCD value and a level request. The arbiter picks one requester, launches a single conversion, captures the 7-bit binary result and returns it with a one-cycle acknowledge. It sits between the requesting blocks and a single `bcd2bin` instance; both share `clk` and `rst_n`.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters (2..8).
- `IDXW`, default 2: index width, must equal ceil(log2(NREQ)).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in NREQ: per-requester level request; held high until its `ack` pulse.
- `dig1_in` in 4*NREQ: tens digit; slice [4i+3:4i] belongs to requester i; stable while `req[i]` is high.
- `dig0_in` in 4*NREQ: units digit; same slicing as `dig1_in`.
- `ack` out NREQ: one-hot, one-cycle pulse; marks the result for that requester as valid.
- `bin_out` out 7: result; valid during `ack`; held until the next `ack`.
- `err` out 1: invalid-digit flag; valid during `ack`.
- `busy` out 1: high in every state except IDLE.
- `conv_start` out 1: one-cycle start pulse to the converter.
- `conv_dig1` out 4, `conv_dig0` out 4: digits latched for the converter; stable from ISSUE until the next grant.
- `conv_bin` in 7, `conv_ready` in 1, `conv_done_tick` in 1: converter outputs.

## Operation
States are IDLE, ISSUE, WAIT and RESP. All outputs are registered.
- **IDLE**
  - If `|req` and `conv_ready` are both high, select the winner by round robin.
  - Search order is `last+1`, `last+2`, … modulo NREQ.
  - Latch the winner index and its digits into `conv_dig1`/`conv_dig0`, then go to ISSUE.
  - If `conv_ready` is low, stay in IDLE.
- **ISSUE**: assert `conv_start` for exactly this cycle, then go to WAIT.
- **WAIT**: on `conv_done_tick`, capture `conv_bin` into `bin_out`, clear `err`, then go to RESP. Hold otherwise. There is no timeout.
- **RESP**: assert `ack[idx]` for one cycle, set `last = idx`, then go to IDLE.

Boundary and rule details:
- A requester must drop `req` on the edge that ends its `ack` cycle. If `req[i]` is still high in the following IDLE cycle, it is treated as a new request.
- If `req[i]` drops before `ack`, the transaction still completes and `ack[i]` still pulses.
- Requests are never pre-empted. Only one conversion is in flight at any time.
- Fairness: a requester that is continuously asserting waits at most NREQ-1 other transactions.
- No arithmetic is done in this block. Digit ranges are handled only by the optional check below.

## Timing
Reset values (asynchronous, while `rst_n` is low):
- State is IDLE.
- `ack`=0, `bin_out`=0, `err`=0, `busy`=0, `conv_start`=0, `conv_dig1`=0, `conv_dig0`=0.
- `last` = NREQ-1, so requester 0 wins first.

Latency:
- Request sampled in IDLE at cycle k.
- `conv_start` is high in cycle k+1.
- Converter asserts `conv_done_tick` L cycles later (L ≥ 1).
- `ack` is high in cycle k+2+L.
- The next grant can be sampled in cycle k+3+L.

Reset asserted mid-transaction (ISSUE/WAIT/RESP): the transaction is abandoned and no `ack` is issued. After release, the request is re-arbitrated from IDLE with `last` = NREQ-1.

## Configuration
- Macro: `BCDBIN_ARB_DIGIT_CHECK_EN`.
- Defined: in IDLE, if the winner's `dig1` > 9 or `dig0` > 9, skip ISSUE and WAIT and go directly to RESP with `bin_out`=7'h7F and `err`=1. `conv_start` is not asserted, and `ack` arrives 1 cycle after the grant.
- Undefined: digits pass through unchecked, `err` is tied to 0, and the result is whatever the converter returns.

## Test plan
- **Single conversion**: `req[0]`, `dig1`=4, `dig0`=2 → one `conv_start` pulse, then `ack`=4'b0001 with `bin_out`=42; `ack` is k+2+L cycles after the request.
- **All four requesting at once**: inputs (9,9), (0,0), (1,5), (7,3) → acks in order 0,1,2,3 with `bin_out` = 99, 0, 15, 73; `busy` stays high between transactions except for a single IDLE cycle.
- **Fairness**: `req[1]` and `req[3]` held continuously (re-asserted after each ack) for 8 transactions → grant sequence 1,3,1,3,1,3,1,3.
- **Converter not ready**: `conv_ready`=0 with `req[2]` high → `conv_start` stays 0 and the state stays IDLE; raising `conv_ready` → ISSUE on the next cycle.
- **Reset in WAIT**: assert `rst_n`=0 during WAIT → all outputs 0 immediately and no `ack`; after release with `req[2]` still high → a fresh grant to 2 and a correct result.
- **Invalid digit**: `dig0`=4'hA on `req[1]`. With `BCDBIN_ARB_DIGIT_CHECK_EN` → `ack[1]` with `err`=1, `bin_out`=127, and no `conv_start`. Without it → `conv_start` issued and `err`=0.
